// File: rtl/jtframe_sdram_pkg.sv
// Shared types for the SDRAM bank arbiter.
//   state_t      arbiter FSM states (IDLE, ISSUE, DATA)
//   BANKS        number of ROM bank requesters
//   bank_idx_t   bank index type
//   bank_onehot  index -> one-hot bank vector
package jtframe_sdram_pkg;

    localparam int BANKS = 4;

    typedef logic [1:0] bank_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DATA  = 2'd2
    } state_t;

    function automatic logic [BANKS-1:0] bank_onehot(input bank_idx_t idx);
        logic [BANKS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/jtframe_sdram_rr_pick.sv
// Combinational 4-way request picker.
//   req_i    per-bank request vector
//   ptr_i    round-robin start position (ignored with fixed priority)
//   idx_o    selected bank
//   valid_o  at least one request present
// Build option JTFRAME_ARB_FIXPRIO_EN: fixed priority bank0 > 1 > 2 > 3.
// Default: round-robin, first request found at ptr_i, ptr_i+1, ... (mod 4).
module jtframe_sdram_rr_pick
    import jtframe_sdram_pkg::*;
(
    input  logic [BANKS-1:0] req_i,
    input  bank_idx_t        ptr_i,
    output bank_idx_t        idx_o,
    output logic             valid_o
);

`ifdef JTFRAME_ARB_FIXPRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    // Scan from the lowest priority upwards so the highest priority wins.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = BANKS - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = bank_idx_t'(i);
                valid_o = 1'b1;
            end
        end
    end
`else
    // Offsets scanned farthest-first so the offset nearest the pointer wins;
    // the 2-bit addition wraps naturally modulo 4.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int k = BANKS - 1; k >= 0; k--) begin
            if (req_i[ptr_i + bank_idx_t'(k)]) begin
                idx_o   = ptr_i + bank_idx_t'(k);
                valid_o = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/jtframe_sdram_bank_arb.sv
// SDRAM command/read port arbiter shared by four ROM bank requesters and
// the ROM download (prog) port. One transaction in flight at a time.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ba0..ba3_addr, ba_rd       per-bank read address / level request
//   ba_ack, ba_dst, ba_dok,
//   ba_rdy, data_read          per-bank accept / first word / data valid /
//                              last word pulses, registered read data
//   prog_en, prog_we, prog_ba,
//   prog_addr, prog_ack        download port (owns SDRAM while prog_en)
//   rfsh                       refresh window, blocks new grants
//   cmd_req, cmd_wr, cmd_ba,
//   cmd_addr, cmd_ack          command interface to the SDRAM core
//   rd_valid, rd_data          read words returned by the core
//   busy, tout_err             FSM not idle / sticky read-timeout flag
// Build option JTFRAME_ARB_FIXPRIO_EN: fixed bank priority, no rr pointer.
module jtframe_sdram_bank_arb
    import jtframe_sdram_pkg::*;
#(
    parameter int AW    = 22,
    parameter int BURST = 2,
    parameter int TOUTW = 6
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ba0_addr,
    input  logic [AW-1:0] ba1_addr,
    input  logic [AW-1:0] ba2_addr,
    input  logic [AW-1:0] ba3_addr,
    input  logic [3:0]    ba_rd,
    output logic [3:0]    ba_ack,
    output logic [3:0]    ba_dst,
    output logic [3:0]    ba_dok,
    output logic [3:0]    ba_rdy,
    output logic [15:0]   data_read,
    input  logic          prog_en,
    input  logic          prog_we,
    input  logic [1:0]    prog_ba,
    input  logic [AW-1:0] prog_addr,
    output logic          prog_ack,
    input  logic          rfsh,
    output logic          cmd_req,
    output logic          cmd_wr,
    output logic [1:0]    cmd_ba,
    output logic [AW-1:0] cmd_addr,
    input  logic          cmd_ack,
    input  logic          rd_valid,
    input  logic [15:0]   rd_data,
    output logic          busy,
    output logic          tout_err
);

    localparam int               CW        = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CW-1:0]    LAST_WORD = CW'(BURST - 1);
    localparam logic [TOUTW-1:0] TOUT_MAX  = '1;

    state_t        state_q, state_d;
    bank_idx_t     idx_q, idx_d;
    logic          wr_q, wr_d;
    logic [1:0]    cmd_ba_q, cmd_ba_d;
    logic [AW-1:0] cmd_addr_q, cmd_addr_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [TOUTW-1:0] tout_q, tout_d;
    logic [3:0]    ack_q, ack_d, dst_q, dst_d, dok_q, dok_d, rdy_q, rdy_d;
    logic [15:0]   data_q, data_d;
    logic          prog_ack_q, prog_ack_d;
    logic          tout_err_q, tout_err_d;
    logic          bank_grant;

    bank_idx_t     rr_ptr;
    bank_idx_t     pick_idx;
    logic          pick_vld;
    logic [AW-1:0] pick_addr;
    logic [3:0]    own_oh;

    jtframe_sdram_rr_pick u_pick (
        .req_i   (ba_rd),
        .ptr_i   (rr_ptr),
        .idx_o   (pick_idx),
        .valid_o (pick_vld)
    );

`ifdef JTFRAME_ARB_FIXPRIO_EN
    assign rr_ptr = '0;
`else
    bank_idx_t rr_q;
    assign rr_ptr = rr_q;

    // Pointer moves past the winner only on an actual bank grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= '0;
        end else if (bank_grant) begin
            rr_q <= pick_idx + bank_idx_t'(1);
        end
    end
`endif

    always_comb begin
        unique case (pick_idx)
            2'd0:    pick_addr = ba0_addr;
            2'd1:    pick_addr = ba1_addr;
            2'd2:    pick_addr = ba2_addr;
            default: pick_addr = ba3_addr;
        endcase
    end

    assign own_oh = bank_onehot(idx_q);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wr_d       = wr_q;
        cmd_ba_d   = cmd_ba_q;
        cmd_addr_d = cmd_addr_q;
        wcnt_d     = wcnt_q;
        tout_d     = tout_q;
        data_d     = data_q;
        tout_err_d = tout_err_q;
        ack_d      = '0;
        dst_d      = '0;
        dok_d      = '0;
        rdy_d      = '0;
        prog_ack_d = 1'b0;
        bank_grant = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Download ownership blocks bank reads entirely, even with
                // no write pending.
                if (!rfsh) begin
                    if (prog_en) begin
                        if (prog_we) begin
                            state_d    = ST_ISSUE;
                            wr_d       = 1'b1;
                            cmd_ba_d   = prog_ba;
                            cmd_addr_d = prog_addr;
                        end
                    end else if (pick_vld) begin
                        state_d    = ST_ISSUE;
                        wr_d       = 1'b0;
                        idx_d      = pick_idx;
                        cmd_ba_d   = pick_idx;
                        cmd_addr_d = pick_addr;
                        bank_grant = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (cmd_ack) begin
                    if (wr_q) begin
                        prog_ack_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        ack_d   = own_oh;
                        wcnt_d  = '0;
                        tout_d  = '0;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (rd_valid) begin
                    data_d = rd_data;
                    dok_d  = own_oh;
                    tout_d = '0;
                    wcnt_d = wcnt_q + CW'(1);
                    if (wcnt_q == '0) dst_d = own_oh;
                    if (wcnt_q == LAST_WORD) begin
                        rdy_d   = own_oh;
                        state_d = ST_IDLE;
                    end
                end else if (tout_q == TOUT_MAX) begin
                    // Lost data: release the requester without a data word.
                    tout_err_d = 1'b1;
                    rdy_d      = own_oh;
                    state_d    = ST_IDLE;
                end else begin
                    tout_d = tout_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            wr_q       <= 1'b0;
            cmd_ba_q   <= '0;
            cmd_addr_q <= '0;
            wcnt_q     <= '0;
            tout_q     <= '0;
            ack_q      <= '0;
            dst_q      <= '0;
            dok_q      <= '0;
            rdy_q      <= '0;
            data_q     <= '0;
            prog_ack_q <= 1'b0;
            tout_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wr_q       <= wr_d;
            cmd_ba_q   <= cmd_ba_d;
            cmd_addr_q <= cmd_addr_d;
            wcnt_q     <= wcnt_d;
            tout_q     <= tout_d;
            ack_q      <= ack_d;
            dst_q      <= dst_d;
            dok_q      <= dok_d;
            rdy_q      <= rdy_d;
            data_q     <= data_d;
            prog_ack_q <= prog_ack_d;
            tout_err_q <= tout_err_d;
        end
    end

    assign cmd_req   = (state_q == ST_ISSUE);
    assign busy      = (state_q != ST_IDLE);
    assign cmd_wr    = wr_q;
    assign cmd_ba    = cmd_ba_q;
    assign cmd_addr  = cmd_addr_q;
    assign ba_ack    = ack_q;
    assign ba_dst    = dst_q;
    assign ba_dok    = dok_q;
    assign ba_rdy    = rdy_q;
    assign data_read = data_q;
    assign prog_ack  = prog_ack_q;
    assign tout_err  = tout_err_q;

endmodule
